// File: rtl/mag_est_pipe.sv
// ---------------------------------------------------------------------------
// mag_est_pipe
// Streaming magnitude estimator for signed (X,Y) pairs using the
// alpha-max-plus-beta-min approximation. Coefficient set is chosen per sample
// by a 2-bit mode tag that travels down the pipe with the data.
//   S1: abs(X), abs(Y) at W+1 bits (no wrap on the most negative value)
//   S2: max / min
//   S3: combine -> out_mag_o (registered)
// All stages advance together on en = !out_valid | out_ready; bubbles stay.
// Also keeps peak magnitude and a saturating transfer count.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid_i     input pair valid
//   in_ready_o     block accepts input this cycle (== en)
//   in_x_i, in_y_i signed W-bit samples
//   in_mode_i      coefficient mode, captured with the pair
//   out_valid_o    out_mag_o valid
//   out_ready_i    downstream accepts out_mag_o
//   out_mag_o      unsigned magnitude estimate, OUT_W bits
//   peak_mag_o     largest transferred out_mag since reset/clear
//   sample_cnt_o   saturating count of transferred outputs
//   stats_clr_i    synchronous clear of peak/count (a transfer wins)
// ---------------------------------------------------------------------------
module mag_est_pipe #(
    parameter int W     = 8,
    parameter int OUT_W = W + 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_x_i,
    input  logic [W-1:0]     in_y_i,
    input  logic [1:0]       in_mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_mag_o,
    output logic [OUT_W-1:0] peak_mag_o,
    output logic [CNT_W-1:0] sample_cnt_o,
    input  logic             stats_clr_i
);

    // Absolute value widened by one bit so -2^(W-1) maps to +2^(W-1).
    function automatic logic [W:0] abs_ext(input logic [W-1:0] v);
        logic [W:0] e;
        e = {v[W-1], v};
        if (v[W-1]) begin
            abs_ext = ~e + {{W{1'b0}}, 1'b1};
        end else begin
            abs_ext = e;
        end
    endfunction

    // Alpha-max-plus-beta-min combine; shifts are logical and truncate.
    function automatic logic [OUT_W-1:0] combine(input logic [W:0] mx,
                                                 input logic [W:0] mn,
                                                 input logic [1:0] mode);
        logic [OUT_W-1:0] a;
        logic [OUT_W-1:0] b;
        a = OUT_W'(mx);
        b = OUT_W'(mn);
        case (mode)
            2'd1:    combine = a + (b >> 3'd2) + (b >> 3'd3);
            2'd2:    combine = a - (a >> 3'd4) + (b >> 3'd1) - (b >> 3'd5);
            2'd0,
            2'd3:    combine = a + (b >> 3'd1);
            default: combine = a + (b >> 3'd1);
        endcase
    endfunction

    logic             en_s;
    logic             xfer_s;
    logic [W:0]       ax_s;
    logic [W:0]       ay_s;

    logic             s1_valid_q, s1_valid_d;
    logic [W:0]       s1_ax_q,    s1_ax_d;
    logic [W:0]       s1_ay_q,    s1_ay_d;
    logic [1:0]       s1_mode_q,  s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [W:0]       s2_max_q,   s2_max_d;
    logic [W:0]       s2_min_q,   s2_min_d;
    logic [1:0]       s2_mode_q,  s2_mode_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_mag_q,   out_mag_d;
    logic [OUT_W-1:0] peak_q,      peak_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    assign en_s   = !out_valid_q | out_ready_i;
    assign xfer_s = out_valid_q & out_ready_i;
    assign ax_s   = abs_ext(in_x_i);
    assign ay_s   = abs_ext(in_y_i);

    assign in_ready_o   = en_s;
    assign out_valid_o  = out_valid_q;
    assign out_mag_o    = out_mag_q;
    assign peak_mag_o   = peak_q;
    assign sample_cnt_o = cnt_q;

    // Pipeline next state: every stage moves on en, otherwise all hold.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_ax_d     = s1_ax_q;
        s1_ay_d     = s1_ay_q;
        s1_mode_d   = s1_mode_q;
        s2_valid_d  = s2_valid_q;
        s2_max_d    = s2_max_q;
        s2_min_d    = s2_min_q;
        s2_mode_d   = s2_mode_q;
        out_valid_d = out_valid_q;
        out_mag_d   = out_mag_q;
        if (en_s) begin
            s1_valid_d  = in_valid_i;
            s1_ax_d     = ax_s;
            s1_ay_d     = ay_s;
            s1_mode_d   = in_mode_i;
            s2_valid_d  = s1_valid_q;
            // On a tie both outputs take the same value.
            if (s1_ax_q >= s1_ay_q) begin
                s2_max_d = s1_ax_q;
                s2_min_d = s1_ay_q;
            end else begin
                s2_max_d = s1_ay_q;
                s2_min_d = s1_ax_q;
            end
            s2_mode_d   = s1_mode_q;
            out_valid_d = s2_valid_q;
            out_mag_d   = combine(s2_max_q, s2_min_q, s2_mode_q);
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Stats next state: a transfer in the same cycle as a clear wins.
    always_comb begin
        peak_d = peak_q;
        cnt_d  = cnt_q;
        if (xfer_s) begin
            if (stats_clr_i) begin
                peak_d = out_mag_q;
                cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                peak_d = (out_mag_q > peak_q) ? out_mag_q : peak_q;
                cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                                                  : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (stats_clr_i) begin
            peak_d = {OUT_W{1'b0}};
            cnt_d  = {CNT_W{1'b0}};
        end else begin
            peak_d = peak_q;
            cnt_d  = cnt_q;
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_ax_q     <= {(W+1){1'b0}};
            s1_ay_q     <= {(W+1){1'b0}};
            s1_mode_q   <= 2'd0;
            s2_valid_q  <= 1'b0;
            s2_max_q    <= {(W+1){1'b0}};
            s2_min_q    <= {(W+1){1'b0}};
            s2_mode_q   <= 2'd0;
            out_valid_q <= 1'b0;
            out_mag_q   <= {OUT_W{1'b0}};
            peak_q      <= {OUT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ax_q     <= s1_ax_d;
            s1_ay_q     <= s1_ay_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            s2_max_q    <= s2_max_d;
            s2_min_q    <= s2_min_d;
            s2_mode_q   <= s2_mode_d;
            out_valid_q <= out_valid_d;
            out_mag_q   <= out_mag_d;
            peak_q      <= peak_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mag_est_pipe.sv
// ---------------------------------------------------------------------------
// tb_mag_est_pipe
// Directed bench for mag_est_pipe (W=8). A second instance with CNT_W=2
// shares all inputs so counter saturation can be observed.
// ---------------------------------------------------------------------------
module tb_mag_est_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [7:0] in_y;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_mag;
    logic [8:0] peak_mag;
    logic [15:0] sample_cnt;
    logic       stats_clr;

    logic       in_ready_c2;
    logic       out_valid_c2;
    logic [8:0] out_mag_c2;
    logic [8:0] peak_mag_c2;
    logic [1:0] sample_cnt_c2;

    int tests_run;
    int tests_failed;

    mag_est_pipe #(.W(8), .OUT_W(9), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_x_i(in_x), .in_y_i(in_y), .in_mode_i(in_mode),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_mag_o(out_mag), .peak_mag_o(peak_mag),
        .sample_cnt_o(sample_cnt), .stats_clr_i(stats_clr)
    );

    mag_est_pipe #(.W(8), .OUT_W(9), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready_c2),
        .in_x_i(in_x), .in_y_i(in_y), .in_mode_i(in_mode),
        .out_valid_o(out_valid_c2), .out_ready_i(out_ready),
        .out_mag_o(out_mag_c2), .peak_mag_o(peak_mag_c2),
        .sample_cnt_o(sample_cnt_c2), .stats_clr_i(stats_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int x, input int y, input int m);
        in_valid = v;
        in_x     = 8'(x);
        in_y     = 8'(y);
        in_mode  = 2'(m);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 0);
        out_ready = 1'b1;
        stats_clr = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
        tests_run++;
        if (out_mag !== 9'd0) begin tests_failed++; $display("FAIL reset_out_mag: got %0d expected 0", out_mag); end
        tests_run++;
        if (peak_mag !== 9'd0 || sample_cnt !== 16'd0) begin
            tests_failed++; $display("FAIL reset_stats: got peak %0d cnt %0d expected 0 0", peak_mag, sample_cnt);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0d expected 1", in_ready); end
    endtask

    task automatic test_latency;
        drive(1'b1, 3, -4, 0);
        cyc();
        drive(1'b0, 0, 0, 0);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_c1: got out_valid %0d expected 0", out_valid); end
        cyc();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_c2: got out_valid %0d expected 0", out_valid); end
        cyc();
        tests_run++;
        if (out_valid !== 1'b1 || out_mag !== 9'd5) begin
            tests_failed++; $display("FAIL latency_c3: got valid %0d mag %0d expected 1 5", out_valid, out_mag);
        end
        cyc();
        tests_run++;
        if (out_valid !== 1'b0 || sample_cnt !== 16'd1 || peak_mag !== 9'd5) begin
            tests_failed++; $display("FAIL latency_xfer: got valid %0d cnt %0d peak %0d expected 0 1 5", out_valid, sample_cnt, peak_mag);
        end
    endtask

    task automatic test_modes;
        int vx[8]  = '{3, -128, -128, -128, -128, 5, 0, -128};
        int vy[8]  = '{-4, 127, 127, 127, 127, -5, 0, -128};
        int vm[8]  = '{1, 0, 1, 2, 3, 0, 2, 2};
        int exp[8] = '{4, 191, 174, 180, 191, 7, 0, 180};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vx[i], vy[i], vm[i]);
            cyc();
            drive(1'b0, 0, 0, 0);
            cyc();
            cyc();
            tests_run++;
            if (out_valid !== 1'b1 || out_mag !== 9'(exp[i])) begin
                tests_failed++;
                $display("FAIL mode_vec%0d: got valid %0d mag %0d expected 1 %0d", i, out_valid, out_mag, exp[i]);
            end
            cyc();
        end
    endtask

    task automatic test_back_to_back;
        int exp[4] = '{191, 174, 191, 174};
        for (int e = 0; e < 6; e++) begin
            if (e < 4) drive(1'b1, -128, 127, e % 2);
            else       drive(1'b0, 0, 0, 0);
            cyc();
            tests_run++;
            if (e >= 2) begin
                if (out_valid !== 1'b1 || out_mag !== 9'(exp[e-2]) || in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_%0d: got valid %0d mag %0d rdy %0d expected 1 %0d 1", e, out_valid, out_mag, in_ready, exp[e-2]);
                end
            end else begin
                if (out_valid !== 1'b0) begin
                    tests_failed++; $display("FAIL b2b_%0d: got valid %0d expected 0", e, out_valid);
                end
            end
        end
        cyc();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got valid %0d expected 0", out_valid); end
    endtask

    task automatic test_backpressure;
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 3, -4, 0);   cyc();
        drive(1'b1, -128, 127, 0); cyc();
        drive(1'b1, 7, 0, 0);    cyc();
        drive(1'b0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_mag !== 9'd5 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_%0d: got valid %0d mag %0d rdy %0d expected 1 5 0", i, out_valid, out_mag, in_ready);
            end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_rdy: got %0d expected 1", in_ready); end
        cyc();
        tests_run++;
        if (out_valid !== 1'b1 || out_mag !== 9'd191) begin
            tests_failed++; $display("FAIL release_r2: got valid %0d mag %0d expected 1 191", out_valid, out_mag);
        end
        cyc();
        tests_run++;
        if (out_valid !== 1'b1 || out_mag !== 9'd7) begin
            tests_failed++; $display("FAIL release_r3: got valid %0d mag %0d expected 1 7", out_valid, out_mag);
        end
        cyc();
        tests_run++;
        if (out_valid !== 1'b0 || sample_cnt !== 16'd3 || peak_mag !== 9'd191) begin
            tests_failed++;
            $display("FAIL release_end: got valid %0d cnt %0d peak %0d expected 0 3 191", out_valid, sample_cnt, peak_mag);
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        drive(1'b1, 3, -4, 0);   cyc();
        drive(1'b1, 9, 0, 0);    cyc();
        drive(1'b1, 7, 0, 0);    cyc();
        drive(1'b0, 0, 0, 0);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_full: got valid %0d expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_mag !== 9'd0 || peak_mag !== 9'd0 || sample_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL midrst_zero: got valid %0d mag %0d peak %0d cnt %0d expected 0 0 0 0", out_valid, out_mag, peak_mag, sample_cnt);
        end
        out_ready = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                tests_failed++; $display("FAIL midrst_after%0d: got valid %0d rdy %0d expected 0 1", i, out_valid, in_ready);
            end
            cyc();
        end
    endtask

    task automatic test_stats;
        do_reset();
        drive(1'b1, 3, -4, 0);     cyc();
        drive(1'b1, -128, 127, 0); cyc();
        drive(1'b1, 7, 0, 0);      cyc();
        drive(1'b1, 9, 0, 0);      cyc();
        drive(1'b0, 0, 0, 0);      cyc();
        cyc();
        tests_run++;
        if (out_valid !== 1'b1 || out_mag !== 9'd9 || peak_mag !== 9'd191 || sample_cnt !== 16'd3 || sample_cnt_c2 !== 2'd3) begin
            tests_failed++;
            $display("FAIL stats_pre: got valid %0d mag %0d peak %0d cnt %0d cnt2 %0d expected 1 9 191 3 3",
                     out_valid, out_mag, peak_mag, sample_cnt, sample_cnt_c2);
        end
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        tests_run++;
        if (peak_mag !== 9'd9 || sample_cnt !== 16'd1 || sample_cnt_c2 !== 2'd1) begin
            tests_failed++;
            $display("FAIL stats_clr_xfer: got peak %0d cnt %0d cnt2 %0d expected 9 1 1", peak_mag, sample_cnt, sample_cnt_c2);
        end
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        tests_run++;
        if (peak_mag !== 9'd0 || sample_cnt !== 16'd0) begin
            tests_failed++; $display("FAIL stats_clr_only: got peak %0d cnt %0d expected 0 0", peak_mag, sample_cnt);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i + 1, 0, 0);
            cyc();
        end
        drive(1'b0, 0, 0, 0);
        repeat (5) cyc();
        tests_run++;
        if (sample_cnt !== 16'd5) begin tests_failed++; $display("FAIL sat_cnt16: got %0d expected 5", sample_cnt); end
        tests_run++;
        if (sample_cnt_c2 !== 2'd3) begin tests_failed++; $display("FAIL sat_cnt2: got %0d expected 3", sample_cnt_c2); end
        tests_run++;
        if (peak_mag !== 9'd5) begin tests_failed++; $display("FAIL sat_peak: got %0d expected 5", peak_mag); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        out_ready    = 1'b1;
        stats_clr    = 1'b0;
        drive(1'b0, 0, 0, 0);
        test_reset();
        test_latency();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_stats();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
